// File: rtl/id_ex_stage_pkg.sv
// Shared datapath definitions for the decode/execute boundary and the ALU:
// datapath widths and the ALU operation codes.
package id_ex_stage_pkg;

    localparam int WIDTH            = 32;
    localparam int ALUCONTROL_WIDTH = 4;
    localparam int REGADDR_WIDTH    = 5;

    localparam logic [ALUCONTROL_WIDTH-1:0] ALU_AND = 4'b0000;
    localparam logic [ALUCONTROL_WIDTH-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALUCONTROL_WIDTH-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALUCONTROL_WIDTH-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALUCONTROL_WIDTH-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALUCONTROL_WIDTH-1:0] ALU_SLL = 4'b1000;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select: the EX/MEM result wins over the MEM/WB result,
// and register $0 is never forwarded.
module fwd_mux #(
    parameter int WIDTH         = id_ex_stage_pkg::WIDTH,
    parameter int REGADDR_WIDTH = id_ex_stage_pkg::REGADDR_WIDTH
) (
    input  logic [REGADDR_WIDTH-1:0] src_addr_i,
    input  logic [WIDTH-1:0]         reg_data_i,
    input  logic                     exmem_reg_write_i,
    input  logic [REGADDR_WIDTH-1:0] exmem_rd_i,
    input  logic [WIDTH-1:0]         exmem_result_i,
    input  logic                     memwb_reg_write_i,
    input  logic [REGADDR_WIDTH-1:0] memwb_rd_i,
    input  logic [WIDTH-1:0]         memwb_result_i,
    output logic [WIDTH-1:0]         data_o
);

    logic src_nonzero;

    always_comb begin
        src_nonzero = (src_addr_i != '0);
        data_o      = reg_data_i;
        if (exmem_reg_write_i && src_nonzero && (exmem_rd_i == src_addr_i)) begin
            data_o = exmem_result_i;
        end else if (memwb_reg_write_i && src_nonzero && (memwb_rd_i == src_addr_i)) begin
            data_o = memwb_result_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarded ALU operand selection and
// load-use hazard detection; ALU-side outputs add no latency after the register.
module id_ex_stage #(
    parameter int WIDTH            = id_ex_stage_pkg::WIDTH,
    parameter int ALUCONTROL_WIDTH = id_ex_stage_pkg::ALUCONTROL_WIDTH,
    parameter int REGADDR_WIDTH    = id_ex_stage_pkg::REGADDR_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_n,
    input  logic                        id_valid_i,
    input  logic [WIDTH-1:0]            id_rs_data_i,
    input  logic [WIDTH-1:0]            id_rt_data_i,
    input  logic [WIDTH-1:0]            id_imm_i,
    input  logic [4:0]                  id_shamt_i,
    input  logic [REGADDR_WIDTH-1:0]    id_rs_addr_i,
    input  logic [REGADDR_WIDTH-1:0]    id_rt_addr_i,
    input  logic [REGADDR_WIDTH-1:0]    id_rd_addr_i,
    input  logic [ALUCONTROL_WIDTH-1:0] id_alu_ctrl_i,
    input  logic                        id_alu_src_i,
    input  logic                        id_shift_i,
    input  logic                        id_reg_dst_i,
    input  logic                        id_reg_write_i,
    input  logic                        id_mem_read_i,
    input  logic                        id_mem_write_i,
    input  logic                        id_mem_to_reg_i,
    input  logic                        stall_i,
    input  logic                        flush_i,
    input  logic                        exmem_reg_write_i,
    input  logic [REGADDR_WIDTH-1:0]    exmem_rd_i,
    input  logic [WIDTH-1:0]            exmem_result_i,
    input  logic                        memwb_reg_write_i,
    input  logic [REGADDR_WIDTH-1:0]    memwb_rd_i,
    input  logic [WIDTH-1:0]            memwb_result_i,
    output logic [WIDTH-1:0]            src1_o,
    output logic [WIDTH-1:0]            src2_o,
    output logic [ALUCONTROL_WIDTH-1:0] alu_ctrl_o,
    output logic                        ex_valid_o,
    output logic [WIDTH-1:0]            ex_store_data_o,
    output logic [REGADDR_WIDTH-1:0]    ex_wr_addr_o,
    output logic                        ex_reg_write_o,
    output logic                        ex_mem_read_o,
    output logic                        ex_mem_write_o,
    output logic                        ex_mem_to_reg_o,
    output logic                        load_use_o
);

    import id_ex_stage_pkg::*;

    typedef struct packed {
        logic                        valid;
        logic [WIDTH-1:0]            rs_data;
        logic [WIDTH-1:0]            rt_data;
        logic [WIDTH-1:0]            imm;
        logic [4:0]                  shamt;
        logic [REGADDR_WIDTH-1:0]    rs_addr;
        logic [REGADDR_WIDTH-1:0]    rt_addr;
        logic [REGADDR_WIDTH-1:0]    rd_addr;
        logic [ALUCONTROL_WIDTH-1:0] alu_ctrl;
        logic                        alu_src;
        logic                        shift;
        logic                        reg_dst;
        logic                        reg_write;
        logic                        mem_read;
        logic                        mem_write;
        logic                        mem_to_reg;
    } idex_t;

    idex_t idex_q, idex_d, bubble, captured;
    logic [WIDTH-1:0] rs_fwd, rt_fwd;

    always_comb begin
        bubble          = '0;
        bubble.alu_ctrl = ALUCONTROL_WIDTH'(ALU_ADD);

        captured            = '0;
        captured.valid      = id_valid_i;
        captured.rs_data    = id_rs_data_i;
        captured.rt_data    = id_rt_data_i;
        captured.imm        = id_imm_i;
        captured.shamt      = id_shamt_i;
        captured.rs_addr    = id_rs_addr_i;
        captured.rt_addr    = id_rt_addr_i;
        captured.rd_addr    = id_rd_addr_i;
        captured.alu_ctrl   = id_alu_ctrl_i;
        captured.alu_src    = id_alu_src_i;
        captured.shift      = id_shift_i;
        captured.reg_dst    = id_reg_dst_i;
        captured.reg_write  = id_reg_write_i;
        captured.mem_read   = id_mem_read_i;
        captured.mem_write  = id_mem_write_i;
        captured.mem_to_reg = id_mem_to_reg_i;

        // Flush beats stall; stall beats the load-use bubble so a held load stays put.
        if (flush_i) begin
            idex_d = bubble;
        end else if (stall_i) begin
            idex_d = idex_q;
        end else if (load_use_o) begin
            idex_d = bubble;
        end else begin
            idex_d = captured;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            idex_q <= bubble;
        end else begin
            idex_q <= idex_d;
        end
    end

    fwd_mux #(.WIDTH(WIDTH), .REGADDR_WIDTH(REGADDR_WIDTH)) u_fwd_rs (
        .src_addr_i        (idex_q.rs_addr),
        .reg_data_i        (idex_q.rs_data),
        .exmem_reg_write_i (exmem_reg_write_i),
        .exmem_rd_i        (exmem_rd_i),
        .exmem_result_i    (exmem_result_i),
        .memwb_reg_write_i (memwb_reg_write_i),
        .memwb_rd_i        (memwb_rd_i),
        .memwb_result_i    (memwb_result_i),
        .data_o            (rs_fwd)
    );

    fwd_mux #(.WIDTH(WIDTH), .REGADDR_WIDTH(REGADDR_WIDTH)) u_fwd_rt (
        .src_addr_i        (idex_q.rt_addr),
        .reg_data_i        (idex_q.rt_data),
        .exmem_reg_write_i (exmem_reg_write_i),
        .exmem_rd_i        (exmem_rd_i),
        .exmem_result_i    (exmem_result_i),
        .memwb_reg_write_i (memwb_reg_write_i),
        .memwb_rd_i        (memwb_rd_i),
        .memwb_result_i    (memwb_result_i),
        .data_o            (rt_fwd)
    );

    always_comb begin
        src1_o          = idex_q.shift ? {{(WIDTH-5){1'b0}}, idex_q.shamt} : rs_fwd;
        src2_o          = idex_q.alu_src ? idex_q.imm : rt_fwd;
        alu_ctrl_o      = idex_q.alu_ctrl;
        ex_valid_o      = idex_q.valid;
        ex_store_data_o = rt_fwd;
        ex_wr_addr_o    = idex_q.reg_dst ? idex_q.rd_addr : idex_q.rt_addr;
        ex_reg_write_o  = idex_q.valid & idex_q.reg_write;
        ex_mem_read_o   = idex_q.valid & idex_q.mem_read;
        ex_mem_write_o  = idex_q.valid & idex_q.mem_write;
        ex_mem_to_reg_o = idex_q.mem_to_reg;
        load_use_o      = ex_mem_read_o && (ex_wr_addr_o != '0) && id_valid_i &&
                          ((ex_wr_addr_o == id_rs_addr_i) || (ex_wr_addr_o == id_rt_addr_i));
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: each issued cycle pushes the expected
// EX-side outputs, which are popped and compared one cycle later.
module tb_id_ex_stage;

    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_SLL = 4'b1000;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        id_valid_i;
    logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
    logic [4:0]  id_shamt_i, id_rs_addr_i, id_rt_addr_i, id_rd_addr_i;
    logic [3:0]  id_alu_ctrl_i;
    logic        id_alu_src_i, id_shift_i, id_reg_dst_i, id_reg_write_i;
    logic        id_mem_read_i, id_mem_write_i, id_mem_to_reg_i;
    logic        stall_i, flush_i;
    logic        exmem_reg_write_i, memwb_reg_write_i;
    logic [4:0]  exmem_rd_i, memwb_rd_i;
    logic [31:0] exmem_result_i, memwb_result_i;
    logic [31:0] src1_o, src2_o, ex_store_data_o;
    logic [3:0]  alu_ctrl_o;
    logic        ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o;
    logic        ex_mem_to_reg_o, load_use_o;
    logic [4:0]  ex_wr_addr_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic        v;
        logic [31:0] s1, s2, st;
        logic [3:0]  alu;
        logic        rw, mr, mw;
        logic [4:0]  wa;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;

    always #5 clk_i = ~clk_i;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .id_valid_i(id_valid_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
        .id_imm_i(id_imm_i), .id_shamt_i(id_shamt_i), .id_rs_addr_i(id_rs_addr_i),
        .id_rt_addr_i(id_rt_addr_i), .id_rd_addr_i(id_rd_addr_i), .id_alu_ctrl_i(id_alu_ctrl_i),
        .id_alu_src_i(id_alu_src_i), .id_shift_i(id_shift_i), .id_reg_dst_i(id_reg_dst_i),
        .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
        .id_mem_write_i(id_mem_write_i), .id_mem_to_reg_i(id_mem_to_reg_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i),
        .exmem_result_i(exmem_result_i), .memwb_reg_write_i(memwb_reg_write_i),
        .memwb_rd_i(memwb_rd_i), .memwb_result_i(memwb_result_i),
        .src1_o(src1_o), .src2_o(src2_o), .alu_ctrl_o(alu_ctrl_o),
        .ex_valid_o(ex_valid_o), .ex_store_data_o(ex_store_data_o),
        .ex_wr_addr_o(ex_wr_addr_o), .ex_reg_write_o(ex_reg_write_o),
        .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
        .ex_mem_to_reg_o(ex_mem_to_reg_o), .load_use_o(load_use_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic id_set(input logic v, input logic [3:0] alu,
                          input logic [4:0] rs, input logic [31:0] rsd,
                          input logic [4:0] rt, input logic [31:0] rtd,
                          input logic [4:0] rd, input logic [31:0] imm, input logic [4:0] sh,
                          input logic asrc, input logic shf, input logic dst, input logic rw,
                          input logic mr, input logic mw, input logic m2r);
        id_valid_i = v;      id_alu_ctrl_i = alu;
        id_rs_addr_i = rs;   id_rs_data_i = rsd;
        id_rt_addr_i = rt;   id_rt_data_i = rtd;
        id_rd_addr_i = rd;   id_imm_i = imm;  id_shamt_i = sh;
        id_alu_src_i = asrc; id_shift_i = shf; id_reg_dst_i = dst; id_reg_write_i = rw;
        id_mem_read_i = mr;  id_mem_write_i = mw; id_mem_to_reg_i = m2r;
    endtask

    task automatic fwd_set(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                           input logic mrw, input logic [4:0] mrd, input logic [31:0] mres);
        exmem_reg_write_i = erw; exmem_rd_i = erd; exmem_result_i = eres;
        memwb_reg_write_i = mrw; memwb_rd_i = mrd; memwb_result_i = mres;
    endtask

    task automatic push(input string tag, input logic v, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [31:0] st, input logic [3:0] alu,
                        input logic rw, input logic mr, input logic mw, input logic [4:0] wa);
        exp_t e;
        e.tag = tag; e.v = v; e.s1 = s1; e.s2 = s2; e.st = st; e.alu = alu;
        e.rw = rw; e.mr = mr; e.mw = mw; e.wa = wa;
        last_exp = e;
        sb.push_back(e);
    endtask

    task automatic push_bubble(input string tag);
        push(tag, 1'b0, 32'd0, 32'd0, 32'd0, A_ADD, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic push_same(input string tag);
        exp_t e;
        e = last_exp;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // One clock edge, then pop the oldest expectation and compare the EX side.
    task automatic tick();
        exp_t e;
        @(posedge clk_i);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            $display("txn %-10s valid=%0b src1=%h src2=%h store=%h alu=%b wr=%0d lu=%0b",
                     e.tag, ex_valid_o, src1_o, src2_o, ex_store_data_o, alu_ctrl_o,
                     ex_wr_addr_o, load_use_o);
            chk({e.tag, ".valid"}, 32'(ex_valid_o), 32'(e.v));
            chk({e.tag, ".src1"},  src1_o, e.s1);
            chk({e.tag, ".src2"},  src2_o, e.s2);
            chk({e.tag, ".store"}, ex_store_data_o, e.st);
            chk({e.tag, ".alu"},   32'(alu_ctrl_o), 32'(e.alu));
            chk({e.tag, ".rw"},    32'(ex_reg_write_o), 32'(e.rw));
            chk({e.tag, ".mr"},    32'(ex_mem_read_o), 32'(e.mr));
            chk({e.tag, ".mw"},    32'(ex_mem_write_o), 32'(e.mw));
            chk({e.tag, ".wa"},    32'(ex_wr_addr_o), 32'(e.wa));
        end
    endtask

    task automatic issue_lw4();
        id_set(1, A_ADD, 5'd1, 32'd100, 5'd4, 32'd0, 5'd0, 32'd8, 5'd0, 1, 0, 0, 1, 1, 0, 1);
    endtask

    task automatic issue_dep_sub();
        id_set(1, A_SUB, 5'd2, 32'd7, 5'd4, 32'd50, 5'd6, 32'd0, 5'd0, 0, 0, 1, 1, 0, 0, 0);
    endtask

    initial begin
        // Reset while a valid store sits on the ID inputs.
        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        fwd_set(0, 0, 0, 0, 0, 0);
        id_set(1, A_ADD, 5'd1, 32'd5, 5'd2, 32'd9, 5'd0, 32'd4, 5'd0, 1, 0, 0, 0, 0, 1, 0);
        push_bubble("rst");
        tick();
        chk("rst.lu", 32'(load_use_o), 32'd0);
        rst_n = 1'b1;

        id_set(1, A_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'd0, 5'd0, 0, 0, 1, 1, 0, 0, 0);
        push("cap", 1, 32'd5, 32'd7, 32'd7, A_ADD, 1, 0, 0, 5'd3);
        tick();

        fwd_set(1, 5'd3, 32'd100, 1, 5'd3, 32'd200);
        id_set(1, A_ADD, 5'd3, 32'd11, 5'd0, 32'd22, 5'd8, 32'd0, 5'd0, 0, 0, 1, 1, 0, 0, 0);
        push("fwd_ex", 1, 32'd100, 32'd22, 32'd22, A_ADD, 1, 0, 0, 5'd8);
        tick();
        exmem_reg_write_i = 1'b0;
        push("fwd_wb", 1, 32'd200, 32'd22, 32'd22, A_ADD, 1, 0, 0, 5'd8);
        tick();

        fwd_set(1, 5'd0, 32'd100, 1, 5'd0, 32'd200);
        id_set(1, A_ADD, 5'd0, 32'd33, 5'd0, 32'd44, 5'd8, 32'd0, 5'd0, 0, 0, 1, 1, 0, 0, 0);
        push("fwd_r0", 1, 32'd33, 32'd44, 32'd44, A_ADD, 1, 0, 0, 5'd8);
        tick();

        fwd_set(1, 5'd6, 32'd400, 1, 5'd7, 32'd300);
        id_set(1, A_SUB, 5'd6, 32'd1, 5'd7, 32'd2, 5'd9, 32'd0, 5'd0, 0, 0, 1, 1, 0, 0, 0);
        push("fwd_rt", 1, 32'd400, 32'd300, 32'd300, A_SUB, 1, 0, 0, 5'd9);
        tick();
        fwd_set(0, 0, 0, 0, 0, 0);

        id_set(1, A_SLL, 5'd0, 32'd0, 5'd5, 32'd3, 5'd10, 32'd0, 5'd4, 0, 1, 1, 1, 0, 0, 0);
        push("sll", 1, 32'd4, 32'd3, 32'd3, A_SLL, 1, 0, 0, 5'd10);
        tick();

        id_set(1, A_ADD, 5'd1, 32'd5, 5'd2, 32'd9, 5'd0, 32'hFFFF_FFFF, 5'd0, 1, 0, 0, 1, 0, 0, 0);
        push("addi", 1, 32'd5, 32'hFFFF_FFFF, 32'd9, A_ADD, 1, 0, 0, 5'd2);
        tick();

        // Invalid slot with control bits set: controls must read back as zero.
        id_set(0, A_OR, 5'd1, 32'd5, 5'd2, 32'd9, 5'd1, 32'd0, 5'd0, 0, 0, 1, 1, 1, 1, 0);
        push("inv", 0, 32'd5, 32'd9, 32'd9, A_OR, 0, 0, 0, 5'd1);
        tick();

        issue_lw4();
        #1 chk("inv.lu", 32'(load_use_o), 32'd0);
        push("lw", 1, 32'd100, 32'd8, 32'd0, A_ADD, 1, 1, 0, 5'd4);
        tick();

        issue_dep_sub();
        #1 chk("lu_hit", 32'(load_use_o), 32'd1);
        push_bubble("lu_bub");
        tick();
        chk("lu_clr", 32'(load_use_o), 32'd0);
        push("lu_cap", 1, 32'd7, 32'd50, 32'd50, A_SUB, 1, 0, 0, 5'd6);
        tick();

        id_set(1, A_ADD, 5'd1, 32'd100, 5'd0, 32'd0, 5'd0, 32'd8, 5'd0, 1, 0, 0, 1, 1, 0, 1);
        push("lw0", 1, 32'd100, 32'd8, 32'd0, A_ADD, 1, 1, 0, 5'd0);
        tick();
        id_set(1, A_ADD, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 32'd0, 5'd0, 0, 0, 1, 1, 0, 0, 0);
        #1 chk("lu_r0", 32'(load_use_o), 32'd0);
        push("after_lw0", 1, 32'd0, 32'd0, 32'd0, A_ADD, 1, 0, 0, 5'd5);
        tick();

        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_set(1, A_SUB, 5'(i + 1), 32'(1000 + i), 5'(i + 11), $urandom, 5'(i + 20),
                   $urandom, 5'(i), 0, 0, 1, 1, 1, 1, 0);
            push_same("stall");
            tick();
        end
        stall_i = 1'b0;

        issue_lw4();
        push("lw_b", 1, 32'd100, 32'd8, 32'd0, A_ADD, 1, 1, 0, 5'd4);
        tick();
        issue_dep_sub();
        stall_i = 1'b1;
        #1 chk("lu_st", 32'(load_use_o), 32'd1);
        push_same("st_lu");
        tick();
        flush_i = 1'b1;
        push_bubble("fl_st");
        tick();
        stall_i = 1'b0;
        push_bubble("flush");
        tick();
        flush_i = 1'b0;

        push("cap2", 1, 32'd7, 32'd50, 32'd50, A_SUB, 1, 0, 0, 5'd6);
        tick();
        issue_lw4();
        push("lw_c", 1, 32'd100, 32'd8, 32'd0, A_ADD, 1, 1, 0, 5'd4);
        tick();
        issue_dep_sub();
        stall_i = 1'b1;
        rst_n = 1'b0;
        push_bubble("rst_st");
        tick();
        chk("rst_st.lu", 32'(load_use_o), 32'd0);
        rst_n = 1'b1;
        stall_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameters: WIDTH, 32, datapath width; ALUCONTROL_WIDTH, 4, ALU control code width; REGADDR_WIDTH, 5, register-file address width.
REQ-002 SHALL have ports (name direction width meaning): clk_i in 1 clock; rst_n in 1 reset, synchronous and active-low, sampled on the rising edge of clk_i.
REQ-003 SHALL have ID inputs: id_valid_i 1; id_rs_data_i, id_rt_data_i WIDTH register reads; id_imm_i WIDTH sign-extended immediate; id_shamt_i 5; id_rs_addr_i, id_rt_addr_i, id_rd_addr_i REGADDR_WIDTH; id_alu_ctrl_i ALUCONTROL_WIDTH; id_alu_src_i, id_shift_i, id_reg_dst_i, id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i 1 each.
REQ-004 SHALL have pipeline-control inputs: stall_i 1 hold; flush_i 1 squash.
REQ-005 SHALL have forwarding inputs: exmem_reg_write_i 1, exmem_rd_i REGADDR_WIDTH, exmem_result_i WIDTH, memwb_reg_write_i 1, memwb_rd_i REGADDR_WIDTH, memwb_result_i WIDTH.
REQ-006 SHALL have outputs to ALU: src1_o WIDTH, src2_o WIDTH, alu_ctrl_o ALUCONTROL_WIDTH.
REQ-007 SHALL have outputs to EX/MEM: ex_valid_o 1, ex_store_data_o WIDTH, ex_wr_addr_o REGADDR_WIDTH, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o 1 each; hazard output load_use_o 1.

Function
REQ-008 SHALL register all ID inputs into one ID/EX register on the rising edge of clk_i; ALU-side outputs SHALL be combinational from that register plus forwarding inputs (zero added latency to ALU).
REQ-009 Register update priority SHALL be: reset > flush_i (load bubble) > stall_i (hold all contents) > load_use_o (load bubble) > normal capture.
REQ-010 Bubble SHALL be: valid 0, all control bits 0, alu_ctrl 4'b0010 (add), all data and addresses 0.
REQ-011 ex_wr_addr_o SHALL be registered rd when reg_dst=1, else rt.
REQ-012 Forwarded rs SHALL be: exmem_result_i if exmem_reg_write_i and exmem_rd_i==rs and rs!=0; else memwb_result_i if memwb_reg_write_i and memwb_rd_i==rs and rs!=0; else registered rs data. Same rule for rt; EX/MEM SHALL take priority over MEM/WB.
REQ-013 src1_o SHALL be zero-extended registered shamt when shift=1, else forwarded rs.
REQ-014 src2_o SHALL be registered imm when alu_src=1, else forwarded rt; ex_store_data_o SHALL always be forwarded rt.
REQ-015 alu_ctrl_o SHALL equal the registered code unmodified; codes 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 1000 sll (src2 << src1).
REQ-016 load_use_o SHALL be 1 combinationally iff ex_valid_o, ex_mem_read_o, ex_wr_addr_o!=0, id_valid_i, and ex_wr_addr_o equals id_rs_addr_i or id_rt_addr_i.
REQ-017 ex_reg_write_o, ex_mem_read_o, ex_mem_write_o SHALL be forced 0 whenever ex_valid_o=0.
REQ-018 Simultaneous flush_i and stall_i SHALL yield a bubble; simultaneous stall_i and load_use_o SHALL hold contents.

Reset
REQ-019 While rst_n=0 at a rising edge, the register SHALL load the bubble of REQ-010; outputs: ex_valid_o 0, all controls 0, alu_ctrl_o 0010, src1_o/src2_o/ex_store_data_o 0 unless forwarding inputs dictate otherwise, load_use_o 0.
REQ-020 Reset asserted mid-stall or mid-load-use SHALL override both in that cycle.

Structure
REQ-021 WIDTH, ALUCONTROL_WIDTH, REGADDR_WIDTH and the ALU control code constants SHALL live in the shared definitions package/include used by the ALU.
REQ-022 Forwarding selection SHALL be one sub-module, fwd_mux, instantiated twice (rs, rt); the rest SHALL be flat.

Verification
REQ-023 Capture: ID add rs=$1(5), rt=$2(7), alu_src=0, no forwarding -> next cycle src1_o=5, src2_o=7, alu_ctrl_o=0010, ex_valid_o=1.
REQ-024 Forward priority: EX rs=$3, exmem_rd=3 result 100, memwb_rd=3 result 200, both writes 1 -> src1_o=100; exmem_reg_write_i=0 -> src1_o=200; rs=$0 -> src1_o=registered data.
REQ-025 Load-use: EX lw to $4, ID rt=$4 -> load_use_o=1; next cycle ex_valid_o=0, ex_reg_write_o=0, alu_ctrl_o=0010.
REQ-026 Stall/flush: stall_i=1 for 3 cycles with changing ID inputs -> outputs constant; flush_i=1 with stall_i=1 -> bubble next cycle.
REQ-027 Shift/imm: sll shamt=4, rt=$5(3) -> src1_o=4, src2_o=3; addi imm=-1 -> src2_o=32'hFFFFFFFF.
REQ-028 Reset: rst_n=0 during valid sw instruction -> next edge ex_valid_o=0, ex_mem_write_o=0, load_use_o=0.
